// File: rtl/risc_v_core_sequencer.sv
// Multi-cycle FETCH/EXECUTE/MEMORY/WRITEBACK sequencer for an RV32I core: owns PC and IR,
// drives req/ack memory ports with wait-state timeout, aligns loads and reports halt/fault.
module risc_v_core_sequencer #(
  parameter int                  X_LENGTH    = 32,
  parameter logic [X_LENGTH-1:0] RESET_PC    = '0,
  parameter int                  MEM_TIMEOUT = 255,
  parameter int                  RETIRE_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [X_LENGTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  output logic [31:0]         instruction,
  input  logic [X_LENGTH-1:0] ex_pc_next,
  input  logic                ex_need_write_rd,
  input  logic [4:0]          ex_rd_index,
  input  logic [X_LENGTH-1:0] ex_result,
  input  logic                ex_is_load,
  input  logic                ex_is_store,
  input  logic [X_LENGTH-1:0] ex_mem_addr,
  input  logic [X_LENGTH-1:0] ex_store_data,
  input  logic [1:0]          ex_mem_width,
  input  logic                ex_load_unsigned,
  input  logic                ex_halt,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [X_LENGTH-1:0] dmem_addr,
  output logic [1:0]          dmem_width,
  output logic [X_LENGTH-1:0] dmem_wdata,
  input  logic                dmem_ack,
  input  logic [X_LENGTH-1:0] dmem_rdata,
  output logic [X_LENGTH-1:0] pc,
  output logic [4:0]          rd_write_index,
  output logic [X_LENGTH-1:0] rd_write_data,
  output logic                rd_write_enable,
  output logic                halted,
  output logic                fault,
  output logic [1:0]          fault_cause,
  output logic [RETIRE_W-1:0] retire_count
);

  typedef enum logic [2:0] {
    S_FETCH, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_HALT, S_FAULT
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

  state_t                state_q, state_d;
  logic                  go_q;
  logic [X_LENGTH-1:0]   pc_q;
  logic [31:0]           ir_q;
  logic [RETIRE_W-1:0]   retire_q;
  logic [15:0]           tmo_q;
  logic [1:0]            cause_q, cause_d;
  logic                  rd_we_q;
  logic [4:0]            rd_idx_q;
  logic [X_LENGTH-1:0]   rd_data_q;
  logic [X_LENGTH-1:0]   maddr_q, mwdata_q, load_q;
  logic [1:0]            mwidth_q;
  logic                  mwe_q, mload_q, muns_q;
  logic                  misaligned, tmo_hit;

  function automatic logic [X_LENGTH-1:0] load_extend(input logic [X_LENGTH-1:0] word,
                                                      input logic [1:0] off,
                                                      input logic [1:0] width,
                                                      input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (width)
      2'd0:    load_extend = uns ? {{(X_LENGTH-8){1'b0}}, b} : {{(X_LENGTH-8){b[7]}}, b};
      2'd1:    load_extend = uns ? {{(X_LENGTH-16){1'b0}}, h} : {{(X_LENGTH-16){h[15]}}, h};
      default: load_extend = word;
    endcase
  endfunction

  assign misaligned = (ex_mem_width == 2'd1 && ex_mem_addr[0]) ||
                      (ex_mem_width[1] && ex_mem_addr[1:0] != 2'b00);
  assign tmo_hit    = (tmo_q == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Ack is checked before the timeout so an ack on the last allowed cycle still completes.
  always_comb begin
    state_d = state_q;
    cause_d = 2'd0;
    case (state_q)
      S_FETCH: begin
        if (imem_req && imem_ack) state_d = S_EXECUTE;
        else if (imem_req && tmo_hit) begin
          state_d = S_FAULT;
          cause_d = 2'd2;
        end
      end
      S_EXECUTE: begin
        if (ex_halt) state_d = S_HALT;
        else if (ex_is_load || ex_is_store) begin
          if (misaligned) begin
            state_d = S_FAULT;
            cause_d = 2'd1;
          end else begin
            state_d = S_MEMORY;
          end
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        if (dmem_ack) state_d = S_WRITEBACK;
        else if (tmo_hit) begin
          state_d = S_FAULT;
          cause_d = 2'd3;
        end
      end
      S_WRITEBACK: state_d = S_FETCH;
      default:     state_d = state_q;
    endcase
  end

  // go_q holds off the first fetch until the cycle after reset is released.
  always_comb begin
    imem_req = (state_q == S_FETCH) && go_q;
    dmem_req = (state_q == S_MEMORY);
    dmem_we  = dmem_req && mwe_q;
    halted   = (state_q == S_HALT);
    fault    = (state_q == S_FAULT);
  end

  assign imem_addr       = pc_q;
  assign pc              = pc_q;
  assign instruction     = ir_q;
  assign dmem_addr       = maddr_q;
  assign dmem_wdata      = mwdata_q;
  assign dmem_width      = mwidth_q;
  assign rd_write_enable = rd_we_q;
  assign rd_write_index  = rd_idx_q;
  assign rd_write_data   = rd_data_q;
  assign fault_cause     = cause_q;
  assign retire_count    = retire_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      go_q     <= 1'b0;
      pc_q     <= RESET_PC;
      ir_q     <= 32'h0000_0013;
      retire_q <= '0;
      tmo_q    <= '0;
      cause_q  <= 2'd0;
      rd_we_q  <= 1'b0;
    end else begin
      go_q    <= 1'b1;
      rd_we_q <= 1'b0;
      if (imem_req && imem_ack) ir_q <= imem_rdata;
      if (state_q == S_EXECUTE || state_q == S_WRITEBACK) tmo_q <= '0;
      else if ((imem_req && !imem_ack) || (dmem_req && !dmem_ack)) tmo_q <= tmo_q + 16'd1;
      if (state_d == S_FAULT && state_q != S_FAULT) cause_q <= cause_d;
      if (state_q == S_WRITEBACK) begin
        pc_q     <= ex_pc_next;
        retire_q <= retire_q + RETIRE_W'(1);
        rd_we_q  <= ex_need_write_rd && (ex_rd_index != 5'd0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_EXECUTE) begin
      maddr_q  <= ex_mem_addr;
      mwdata_q <= ex_store_data;
      mwidth_q <= ex_mem_width;
      mwe_q    <= ex_is_store;
      mload_q  <= ex_is_load;
      muns_q   <= ex_load_unsigned;
    end
    if (dmem_req && dmem_ack) load_q <= load_extend(dmem_rdata, maddr_q[1:0], mwidth_q, muns_q);
    if (state_q == S_WRITEBACK) begin
      rd_idx_q  <= ex_rd_index;
      rd_data_q <= mload_q ? load_q : ex_result;
    end
  end

endmodule

// File: tb/tb_risc_v_core_sequencer.sv
// Bench for risc_v_core_sequencer: plays instruction/data memory and execute stage,
// compares against a transaction-level model of PC, retire count and register writes.
module tb_risc_v_core_sequencer;
  localparam logic [31:0] RPC = 32'h100;
  localparam int          TMO = 255;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0, instruction;
  logic [31:0] ex_pc_next, ex_result, ex_mem_addr, ex_store_data;
  logic        ex_need_write_rd, ex_is_load, ex_is_store, ex_load_unsigned, ex_halt;
  logic [4:0]  ex_rd_index;
  logic [1:0]  ex_mem_width;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic [1:0]  dmem_width;
  logic [31:0] pc, rd_write_data, retire_count;
  logic [4:0]  rd_write_index;
  logic        rd_write_enable, halted, fault;
  logic [1:0]  fault_cause;

  always #5 clk = ~clk;

  risc_v_core_sequencer #(.X_LENGTH(32), .RESET_PC(RPC), .MEM_TIMEOUT(TMO), .RETIRE_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction),
    .ex_pc_next(ex_pc_next), .ex_need_write_rd(ex_need_write_rd), .ex_rd_index(ex_rd_index),
    .ex_result(ex_result), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data), .ex_mem_width(ex_mem_width),
    .ex_load_unsigned(ex_load_unsigned), .ex_halt(ex_halt),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_width(dmem_width),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc(pc), .rd_write_index(rd_write_index), .rd_write_data(rd_write_data),
    .rd_write_enable(rd_write_enable), .halted(halted), .fault(fault),
    .fault_cause(fault_cause), .retire_count(retire_count)
  );

  // kind: 0 alu, 1 load, 2 store, 3 halt; mode: 0 normal, 1 dmem never acks, 2 reset mid-memory
  typedef struct {
    int          kind;
    logic [31:0] word;
    logic [31:0] pc_next;
    bit          need;
    logic [4:0]  rd;
    logic [31:0] result;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [1:0]  width;
    bit          uns;
    logic [31:0] rdata;
    int          iw;
    int          dw;
    int          mode;
  } instr_t;

  int          checks = 0, errors = 0;
  logic [31:0] m_pc, m_retire;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] addr,
                                           input logic [1:0] width, input bit uns);
    longint unsigned v, span;
    if (width == 2'd2) return word;
    span = (width == 2'd0) ? 64'd256 : 64'd65536;
    v = ({32'h0, word} >> (8 * (addr % 4))) % span;
    if (!uns && v >= span / 2) v = v + 64'h1_0000_0000 - span;
    return v[31:0];
  endfunction

  function automatic instr_t rand_instr(input logic [31:0] cur_pc);
    instr_t t;
    int sel;
    sel       = $urandom_range(0, 9);
    t.kind    = (sel < 5) ? 0 : ((sel < 8) ? 1 : 2);
    t.word    = $urandom;
    t.pc_next = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h0000_FFFC) : cur_pc + 32'd4;
    t.need    = 1'($urandom_range(0, 1));
    t.rd      = 5'($urandom_range(0, 31));
    t.result  = $urandom;
    t.width   = 2'($urandom_range(0, 2));
    t.addr    = $urandom;
    t.addr    = t.addr - (t.addr % ((t.width == 2'd0) ? 1 : ((t.width == 2'd1) ? 2 : 4)));
    t.sdata   = $urandom;
    t.uns     = 1'($urandom_range(0, 1));
    t.rdata   = $urandom;
    t.iw      = $urandom_range(0, 3);
    t.dw      = $urandom_range(0, 3);
    t.mode    = 0;
    return t;
  endfunction

  task automatic clear_ex();
    ex_pc_next = '0; ex_need_write_rd = 1'b0; ex_rd_index = '0; ex_result = '0;
    ex_is_load = 1'b0; ex_is_store = 1'b0; ex_mem_addr = '0; ex_store_data = '0;
    ex_mem_width = '0; ex_load_unsigned = 1'b0; ex_halt = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    clear_ex();
    repeat (n) @(negedge clk);
    chk("rst_pc", pc, RPC);
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_dmem_req", dmem_req, 1'b0);
    chk("rst_rd_we", rd_write_enable, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_cause", fault_cause, 2'd0);
    chk("rst_retire", retire_count, 32'd0);
    chk("rst_ir", instruction, 32'h0000_0013);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_imem_req", imem_req, 1'b1);
    chk("release_imem_addr", imem_addr, RPC);
    m_pc = RPC;
    m_retire = '0;
  endtask

  // Entered and left at a negedge in which the core is fetching (except terminal outcomes).
  task automatic run_instr(input instr_t t);
    int  n, bytes;
    bit  is_mem, mis, exp_we;
    chk("fetch_req", imem_req, 1'b1);
    chk("fetch_addr", imem_addr, m_pc);
    for (int k = 0; k < t.iw; k++) begin
      imem_ack = 1'b0;
      @(negedge clk);
      chk("fetch_wait_req", imem_req, 1'b1);
      chk("fetch_wait_addr", imem_addr, m_pc);
    end
    imem_ack = 1'b1; imem_rdata = t.word;
    @(negedge clk);
    imem_ack = 1'($urandom_range(0, 1)); dmem_ack = 1'($urandom_range(0, 1));
    imem_rdata = $urandom;
    chk("exec_ir", instruction, t.word);
    chk("exec_imem_req", imem_req, 1'b0);
    ex_pc_next = t.pc_next; ex_need_write_rd = t.need; ex_rd_index = t.rd; ex_result = t.result;
    ex_is_load = (t.kind == 1); ex_is_store = (t.kind == 2); ex_halt = (t.kind == 3);
    ex_mem_addr = t.addr; ex_store_data = t.sdata; ex_mem_width = t.width; ex_load_unsigned = t.uns;
    @(negedge clk);
    is_mem = (t.kind == 1 || t.kind == 2);
    bytes  = (t.width == 2'd0) ? 1 : ((t.width == 2'd1) ? 2 : 4);
    mis    = is_mem && ((t.addr % bytes) != 0);
    if (t.kind == 3) begin
      chk("halt_flag", halted, 1'b1);
      chk("halt_fault", fault, 1'b0);
      chk("halt_imem_req", imem_req, 1'b0);
      chk("halt_pc", pc, m_pc);
      chk("halt_retire", retire_count, m_retire);
      imem_ack = 1'b0; dmem_ack = 1'b0; clear_ex();
      return;
    end
    if (mis) begin
      chk("mis_fault", fault, 1'b1);
      chk("mis_cause", fault_cause, 2'd1);
      chk("mis_dmem_req", dmem_req, 1'b0);
      chk("mis_pc", pc, m_pc);
      chk("mis_retire", retire_count, m_retire);
      imem_ack = 1'b0; dmem_ack = 1'b0; clear_ex();
      return;
    end
    if (is_mem) begin
      chk("mem_req", dmem_req, 1'b1);
      chk("mem_we", dmem_we, (t.kind == 2));
      chk("mem_addr", dmem_addr, t.addr);
      chk("mem_width", dmem_width, t.width);
      if (t.kind == 2) chk("mem_wdata", dmem_wdata, t.sdata);
      if (t.mode == 1) begin
        dmem_ack = 1'b0; n = 0;
        while (dmem_req && n < 400) begin
          n++;
          @(negedge clk);
        end
        chk("dmem_timeout_cycles", n, TMO);
        chk("dmem_timeout_fault", fault, 1'b1);
        chk("dmem_timeout_cause", fault_cause, 2'd3);
        chk("dmem_timeout_retire", retire_count, m_retire);
        imem_ack = 1'b0; clear_ex();
        return;
      end
      if (t.mode == 2) begin
        rst_n = 1'b0; dmem_ack = 1'b0;
        @(negedge clk);
        chk("rst_mid_dmem_req", dmem_req, 1'b0);
        chk("rst_mid_pc", pc, RPC);
        chk("rst_mid_retire", retire_count, 32'd0);
        imem_ack = 1'b0; clear_ex();
        return;
      end
      for (int k = 0; k < t.dw; k++) begin
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("mem_wait_req", dmem_req, 1'b1);
        chk("mem_wait_addr", dmem_addr, t.addr);
      end
      dmem_ack = 1'b1; dmem_rdata = t.rdata;
      @(negedge clk);
      dmem_ack = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
    end
    chk("wb_rd_we_idle", rd_write_enable, 1'b0);
    chk("wb_dmem_req", dmem_req, 1'b0);
    chk("wb_imem_req", imem_req, 1'b0);
    @(negedge clk);
    imem_ack = 1'b0; dmem_ack = 1'b0;
    exp_we = t.need && (t.rd != 0);
    chk("rd_we", rd_write_enable, exp_we);
    if (exp_we) begin
      chk("rd_index", rd_write_index, t.rd);
      chk("rd_data", rd_write_data, (t.kind == 1) ? ref_load(t.rdata, t.addr, t.width, t.uns) : t.result);
    end
    m_pc = t.pc_next;
    m_retire = m_retire + 32'd1;
    chk("pc_after", pc, m_pc);
    chk("retire_after", retire_count, m_retire);
    clear_ex();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t t;
    int     n;
    clear_ex();
    do_reset(3);

    t = rand_instr(m_pc);
    t.kind = 0; t.need = 1'b1; t.rd = 5'd1; t.result = 32'd5; t.pc_next = m_pc + 32'd4; t.iw = 0;
    run_instr(t);
    chk("addi_pc", pc, 32'h104);
    chk("addi_retire", retire_count, 32'd1);

    t = rand_instr(m_pc);
    t.kind = 1; t.need = 1'b1; t.rd = 5'd7; t.addr = 32'h203; t.width = 2'd0; t.uns = 1'b0;
    t.rdata = 32'h80FF_1234; t.dw = 3; t.iw = 0; t.pc_next = m_pc + 32'd4;
    run_instr(t);
    chk("lb_value", rd_write_data, 32'hFFFF_FF80);
    t.uns = 1'b1; t.pc_next = m_pc + 32'd4;
    run_instr(t);
    chk("lbu_value", rd_write_data, 32'h0000_0080);
    t.width = 2'd1; t.uns = 1'b0; t.addr = 32'h302; t.rdata = 32'h8001_7FFF; t.pc_next = m_pc + 32'd4;
    run_instr(t);
    chk("lh_value", rd_write_data, 32'hFFFF_8001);

    for (int i = 0; i < 40; i++) begin
      t = rand_instr(m_pc);
      run_instr(t);
    end

    t = rand_instr(m_pc);
    t.kind = 0; t.need = 1'b1; t.rd = 5'd0; t.result = 32'd1; t.pc_next = m_pc + 32'd4;
    run_instr(t);
    chk("x0_no_write", rd_write_enable, 1'b0);
    t = rand_instr(m_pc);
    t.kind = 3;
    run_instr(t);
    for (int i = 0; i < 20; i++) begin
      imem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("halt_hold_imem_req", imem_req, 1'b0);
    end
    chk("halt_hold_flag", halted, 1'b1);
    chk("halt_hold_pc", pc, m_pc);
    chk("halt_hold_retire", retire_count, m_retire);

    do_reset(2);
    t = rand_instr(m_pc);
    t.kind = 2; t.width = 2'd2; t.addr = 32'h202;
    run_instr(t);
    repeat (5) @(negedge clk);
    chk("mis_hold_dmem_req", dmem_req, 1'b0);
    chk("mis_hold_fault", fault, 1'b1);
    chk("mis_hold_retire", retire_count, 32'd0);

    do_reset(2);
    imem_ack = 1'b0; n = 0;
    while (imem_req && n < 400) begin
      n++;
      @(negedge clk);
    end
    chk("imem_timeout_cycles", n, TMO);
    chk("imem_timeout_fault", fault, 1'b1);
    chk("imem_timeout_cause", fault_cause, 2'd2);

    do_reset(2);
    t = rand_instr(m_pc);
    t.kind = 0; t.iw = TMO - 1;
    run_instr(t);
    chk("late_ack_no_fault", fault, 1'b0);
    t = rand_instr(m_pc);
    t.kind = 1; t.mode = 1; t.iw = 0;
    run_instr(t);

    do_reset(2);
    t = rand_instr(m_pc);
    t.kind = 1; t.mode = 2;
    run_instr(t);
    do_reset(1);
    t = rand_instr(m_pc);
    t.kind = 0;
    run_instr(t);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
